// File: rtl/usb_kbd_pkg.sv
// usb_kbd_pkg: shared HID usage constants and feeder FSM encoding for the
// USB keyboard ASCII feeder.
package usb_kbd_pkg;

  localparam logic [7:0] KC_A       = 8'h04;
  localparam logic [7:0] KC_1       = 8'h1E;
  localparam logic [7:0] KC_0       = 8'h27;
  localparam logic [7:0] KC_ENTER   = 8'h28;
  localparam logic [7:0] KC_BKSP    = 8'h2A;
  localparam logic [7:0] KC_TAB     = 8'h2B;
  localparam logic [7:0] KC_SPACE   = 8'h2C;

  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REQ    = 2'd2,
    GAP    = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/ascii_to_hid.sv
// ascii_to_hid: purely combinational translation of one ASCII byte into a
// HID {modifier, keycode} pair for a US keyboard layout. valid is low for
// bytes with no key equivalent.
module ascii_to_hid
  import usb_kbd_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       valid,
  output logic [7:0] modifier,
  output logic [7:0] keycode
);

  // Letter and digit ranges are arithmetic; everything else is a table
  always_comb begin
    valid    = 1'b1;
    modifier = 8'h00;
    keycode  = 8'h00;
    if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      keycode = KC_A + (ascii - 8'h61);
    end else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      modifier = MOD_LSHIFT;
      keycode  = KC_A + (ascii - 8'h41);
    end else if (ascii >= 8'h31 && ascii <= 8'h39) begin
      keycode = KC_1 + (ascii - 8'h31);
    end else begin
      case (ascii)
        8'h30: keycode = KC_0;
        8'h0A: keycode = KC_ENTER;
        8'h0D: keycode = KC_ENTER;
        8'h08: keycode = KC_BKSP;
        8'h09: keycode = KC_TAB;
        8'h20: keycode = KC_SPACE;
        8'h2D: keycode = 8'h2D;
        8'h3D: keycode = 8'h2E;
        8'h5B: keycode = 8'h2F;
        8'h5D: keycode = 8'h30;
        8'h5C: keycode = 8'h31;
        8'h3B: keycode = 8'h33;
        8'h27: keycode = 8'h34;
        8'h60: keycode = 8'h35;
        8'h2C: keycode = 8'h36;
        8'h2E: keycode = 8'h37;
        8'h2F: keycode = 8'h38;
        8'h21: begin modifier = MOD_LSHIFT; keycode = 8'h1E; end
        8'h40: begin modifier = MOD_LSHIFT; keycode = 8'h1F; end
        8'h23: begin modifier = MOD_LSHIFT; keycode = 8'h20; end
        8'h24: begin modifier = MOD_LSHIFT; keycode = 8'h21; end
        8'h25: begin modifier = MOD_LSHIFT; keycode = 8'h22; end
        8'h5E: begin modifier = MOD_LSHIFT; keycode = 8'h23; end
        8'h26: begin modifier = MOD_LSHIFT; keycode = 8'h24; end
        8'h2A: begin modifier = MOD_LSHIFT; keycode = 8'h25; end
        8'h28: begin modifier = MOD_LSHIFT; keycode = 8'h26; end
        8'h29: begin modifier = MOD_LSHIFT; keycode = 8'h27; end
        8'h5F: begin modifier = MOD_LSHIFT; keycode = 8'h2D; end
        8'h2B: begin modifier = MOD_LSHIFT; keycode = 8'h2E; end
        8'h7B: begin modifier = MOD_LSHIFT; keycode = 8'h2F; end
        8'h7D: begin modifier = MOD_LSHIFT; keycode = 8'h30; end
        8'h7C: begin modifier = MOD_LSHIFT; keycode = 8'h31; end
        8'h3A: begin modifier = MOD_LSHIFT; keycode = 8'h33; end
        8'h22: begin modifier = MOD_LSHIFT; keycode = 8'h34; end
        8'h7E: begin modifier = MOD_LSHIFT; keycode = 8'h35; end
        8'h3C: begin modifier = MOD_LSHIFT; keycode = 8'h36; end
        8'h3E: begin modifier = MOD_LSHIFT; keycode = 8'h37; end
        8'h3F: begin modifier = MOD_LSHIFT; keycode = 8'h38; end
        default: valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/usb_keyboard_ascii_feeder.sv
// usb_keyboard_ascii_feeder: buffers an ASCII byte stream in a small FIFO,
// translates each byte to a HID key and issues paced one-cycle key requests.
// Optional build macro ASCII_FEEDER_CRLF_MERGE_EN: an LF popped directly
// after a CR is discarded so CR/LF line endings produce a single Enter.
module usb_keyboard_ascii_feeder
  import usb_kbd_pkg::*;
#(
  parameter int          FIFO_AW    = 4,
  parameter logic [23:0] GAP_CYCLES = 24'd12000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        usb_rstn,
  input  logic [7:0]  ascii_data,
  input  logic        ascii_valid,
  output logic        ascii_ready,
  output logic [15:0] key_value,
  output logic        key_request,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int             DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       pop_byte;

  feeder_state_e    state;
  logic [7:0]       char_q;
  logic [23:0]      gap_cnt;
  logic             map_valid;
  logic [7:0]       map_mod;
  logic [7:0]       map_kc;
`ifdef ASCII_FEEDER_CRLF_MERGE_EN
  logic             prev_cr;
`endif

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign ascii_ready = rstn & usb_rstn & ~fifo_full;
  assign push        = ascii_valid & ascii_ready;
  assign pop         = usb_rstn & (state == IDLE) & ~fifo_empty;
  assign pop_byte    = mem[rd_ptr[FIFO_AW-1:0]];
  assign busy        = ~fifo_empty | (state != IDLE);

  ascii_to_hid u_map (
    .ascii    (char_q),
    .valid    (map_valid),
    .modifier (map_mod),
    .keycode  (map_kc)
  );

  // FIFO storage, written only on an accepted handshake
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= ascii_data;
  end

  // FIFO pointers; a USB disconnect empties the queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!usb_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Pop, translate, request, then wait out the gap before the next byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      char_q      <= '0;
      gap_cnt     <= '0;
      key_value   <= '0;
      key_request <= 1'b0;
      err_cnt     <= '0;
`ifdef ASCII_FEEDER_CRLF_MERGE_EN
      prev_cr     <= 1'b0;
`endif
    end else if (!usb_rstn) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      key_request <= 1'b0;
`ifdef ASCII_FEEDER_CRLF_MERGE_EN
      prev_cr     <= 1'b0;
`endif
    end else begin
      key_request <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
`ifdef ASCII_FEEDER_CRLF_MERGE_EN
            if (prev_cr && pop_byte == 8'h0A) begin
              prev_cr <= 1'b0;
            end else begin
              prev_cr <= (pop_byte == 8'h0D);
              char_q  <= pop_byte;
              state   <= LOOKUP;
            end
`else
            char_q <= pop_byte;
            state  <= LOOKUP;
`endif
          end
        end
        LOOKUP: begin
          if (map_valid) begin
            key_value   <= {map_mod, map_kc};
            key_request <= 1'b1;
            state       <= REQ;
          end else begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        REQ: begin
          gap_cnt <= GAP_CYCLES - 24'd1;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == 24'd0) state <= IDLE;
          else                  gap_cnt <= gap_cnt - 24'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
